iseq_dispatcher_mc: RTL and testbench
=====================================

// Module: iseq_dispatcher_mc
// PURPOSE
//  Multi-lane instruction-sequence front end for the DFI command path. It drains NUM_LANES
//  instruction FIFOs into per-lane one-entry holding registers that feed the instruction
//  dispatcher through valid/ack handshakes. It adds a per-run lane-enable mask, abort with
//  FIFO flush, and a dispatched-instruction counter.
// PARAMETERS
//  NUM_LANES    2   number of instruction lanes (1..8)
//  INSTR_WIDTH  32  instruction word width
//  CNT_WIDTH    16  width of the dispatched-instruction counter
// PORTS
//  clk             in   1                 sole clock
//  rst_n           in   1                 one clock; reset is asynchronous and active-low
//  process_iseq    in   1                 start pulse, sampled in IDLE only
//  lane_mask       in   NUM_LANES         lanes taking part in the run, captured with process_iseq
//  abort_iseq      in   1                 abort request, sampled in RUN only
//  busy            out  1                 run or flush in progress
//  done            out  1                 one-cycle pulse at the end of a run or flush
//  aborted         out  1                 high when the last run ended by abort; held until the next start
//  instr_count     out  CNT_WIDTH         handshakes completed in the current or last run
//  lane_fifo_rd    out  NUM_LANES         FWFT FIFO pop, one bit per lane
//  lane_fifo_empty in   NUM_LANES         FIFO empty, one bit per lane
//  lane_fifo_data  in   NUM_LANES*INSTR_WIDTH  FIFO head word; lane i is at [i*W +: W]
//  disp_valid      out  NUM_LANES         holding register valid, one bit per lane
//  disp_data       out  NUM_LANES*INSTR_WIDTH  holding register contents
//  disp_ack        in   NUM_LANES         dispatcher accepts lane word
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - state=IDLE; busy, done, aborted, instr_count, disp_valid, lane_fifo_rd all 0.
//   - disp_data 0; mask register 0.
//   - Reset mid-run discards all held words without popping.
//  FSM states: IDLE, RUN, FLUSH, plus a registered done pulse.
//  IDLE
//   - process_iseq=1 -> RUN next cycle. Capture lane_mask; clear instr_count and aborted.
//   - A start with an all-zero mask goes to RUN, which completes at once: done is high 1 cycle
//     after busy rises.
//   - abort_iseq is ignored. When both inputs are high, the start wins.
//  RUN, lane i with mask[i]=1
//   - ready_i = ~disp_valid[i] | disp_ack[i].
//   - lane_fifo_rd[i] = ready_i & ~lane_fifo_empty[i].
//   - A pop loads the holding register; disp_valid rises the next cycle.
//   - Back-to-back acks sustain 1 word/cycle/lane.
//   - disp_data is stable while disp_valid=1 and disp_ack=0.
//  Masked-off lanes: never popped, disp_valid stays 0, not considered for completion.
//  Run completion
//   - Condition: every enabled lane has lane_fifo_empty=1 and disp_valid=0 (after an ack).
//   - Next cycle: state=IDLE, busy=0, done=1 for one cycle.
//  Abort: abort_iseq=1 in RUN -> FLUSH next cycle.
//   - A handshake in the abort cycle still completes and is counted.
//   - On entering FLUSH, all disp_valid clear. Their words are dropped and not counted.
//  FLUSH
//   - disp_valid stays 0.
//   - lane_fifo_rd[i] = mask[i] & ~lane_fifo_empty[i], one word/cycle/lane.
//   - When all enabled lanes are empty -> IDLE with done=1 and aborted=1.
//   - process_iseq and abort_iseq are ignored.
//  busy = (state != IDLE), registered. It rises the cycle after process_iseq.
//  instr_count
//   - Adds popcount(disp_valid & disp_ack) each cycle.
//   - Saturates at 2^CNT_WIDTH-1; it does not wrap.
//   - Holds its value in IDLE until the next start.
//  FIFO data is sampled only in a cycle where lane_fifo_rd=1. The block never pops an empty FIFO.
// TESTING
//  - Start, mask=2'b11, lane0 holds 3 words, lane1 holds 2, ack held 1.
//    -> 5 handshakes; lane0 data order preserved; done pulses; instr_count=5; aborted=0.
//  - Lane0 holds 4 words; ack toggles 1,0,1,0.
//    -> disp_data stable through each ack=0 cycle; no pop while full and not acked;
//       completes with instr_count=4.
//  - mask=2'b01, lane1 non-empty.
//    -> lane_fifo_rd[1] never asserts; lane1 disp_valid never asserts; done after lane0 drains.
//  - Abort while lane0 holds 6 words and one word is held in disp.
//    -> FLUSH pops the remaining words at 1/cycle; disp_valid=0; done=1 and aborted=1;
//       instr_count excludes the dropped words.
//  - CNT_WIDTH=3, 10 words.
//    -> instr_count saturates at 7.
//  - rst_n low mid-run.
//    -> all outputs 0 asynchronously; a start after release runs normally.

Source files
------------

// File: rtl/iseq_dispatcher_mc.sv
// ---------------------------------------------------------------------------
// iseq_dispatcher_mc
//
// Multi-lane instruction-sequence front end for the DFI command path.
// Each enabled lane drains its first-word-fall-through instruction FIFO into
// a one-entry holding register. That register drives the instruction
// dispatcher through a valid/ack handshake.
//
// A run starts on process_iseq_i and is limited to the lanes selected by
// lane_mask_i. It ends in one of two ways:
//   - every enabled lane has drained;
//   - abort_iseq_i is raised. Held words are then dropped and the FIFOs are
//     flushed.
// instr_count_o counts completed handshakes and saturates at its maximum.
//
// Ports
//   clk                clock
//   rst_n              asynchronous active-low reset
//   process_iseq_i     start pulse (IDLE only)
//   lane_mask_i        lanes taking part, captured with the start
//   abort_iseq_i       abort request (RUN only)
//   busy_o             run or flush in progress
//   done_o             one-cycle pulse at the end of a run or flush
//   aborted_o          last run ended by abort; held until the next start
//   instr_count_o      handshakes completed in the current or last run
//   lane_fifo_rd_o     per-lane FIFO pop
//   lane_fifo_empty_i  per-lane FIFO empty
//   lane_fifo_data_i   per-lane FIFO head word, lane i at [i*W +: W]
//   disp_valid_o       per-lane holding register valid
//   disp_data_o        per-lane holding register contents
//   disp_ack_i         per-lane dispatcher accept
// ---------------------------------------------------------------------------
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_IDLE  | waiting for process_iseq_i; count and aborted flag hold
// ST_RUN   | draining enabled FIFOs into holding registers
// ST_FLUSH | after abort: holding registers empty, FIFOs popped until empty
module iseq_dispatcher_mc #(
    parameter int NUM_LANES   = 2,
    parameter int INSTR_WIDTH = 32,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             process_iseq_i,
    input  logic [NUM_LANES-1:0]             lane_mask_i,
    input  logic                             abort_iseq_i,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             aborted_o,
    output logic [CNT_WIDTH-1:0]             instr_count_o,
    output logic [NUM_LANES-1:0]             lane_fifo_rd_o,
    input  logic [NUM_LANES-1:0]             lane_fifo_empty_i,
    input  logic [NUM_LANES*INSTR_WIDTH-1:0] lane_fifo_data_i,
    output logic [NUM_LANES-1:0]             disp_valid_o,
    output logic [NUM_LANES*INSTR_WIDTH-1:0] disp_data_o,
    input  logic [NUM_LANES-1:0]             disp_ack_i
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    // Wide enough to hold the count plus up to eight handshakes in one cycle
    // without losing the overflow bit.
    localparam int SUM_W = CNT_WIDTH + 4;

    logic [1:0]                       state_q, state_d;
    logic                             busy_q, busy_d;
    logic                             done_q, done_d;
    logic                             aborted_q, aborted_d;
    logic [NUM_LANES-1:0]             mask_q, mask_d;
    logic [NUM_LANES-1:0]             valid_q, valid_d;
    logic [NUM_LANES*INSTR_WIDTH-1:0] data_q, data_d;
    logic [CNT_WIDTH-1:0]             count_q, count_d;

    logic [NUM_LANES-1:0] ready;
    logic [NUM_LANES-1:0] pop;
    logic [NUM_LANES-1:0] hs;
    logic [NUM_LANES-1:0] lane_idle;
    logic [NUM_LANES-1:0] lane_drained;
    logic                 run_done;
    logic                 flush_done;
    logic [3:0]           hs_cnt;
    logic [SUM_W-1:0]     count_sum;
    logic [CNT_WIDTH-1:0] count_sat;

    // Per-lane handshake and pop decisions.
    always_comb begin
        ready        = '0;
        pop          = '0;
        hs           = '0;
        lane_idle    = '0;
        lane_drained = '0;
        hs_cnt       = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            ready[i]        = ~valid_q[i] | disp_ack_i[i];
            hs[i]           = valid_q[i] & disp_ack_i[i];
            // Masked-off lanes always count as finished.
            lane_idle[i]    = ~mask_q[i] | (lane_fifo_empty_i[i] & ~valid_q[i]);
            lane_drained[i] = ~mask_q[i] | lane_fifo_empty_i[i];
            if (state_q == ST_RUN) begin
                pop[i] = mask_q[i] & ready[i] & ~lane_fifo_empty_i[i];
            end else if (state_q == ST_FLUSH) begin
                pop[i] = mask_q[i] & ~lane_fifo_empty_i[i];
            end
            hs_cnt = hs_cnt + 4'(hs[i]);
        end
        run_done   = &lane_idle;
        flush_done = &lane_drained;
    end

    // Saturating count update.
    always_comb begin
        count_sum = SUM_W'(count_q) + SUM_W'(hs_cnt);
        if (count_sum[SUM_W-1:CNT_WIDTH] != '0) begin
            count_sat = '1;
        end else begin
            count_sat = count_sum[CNT_WIDTH-1:0];
        end
    end

    // Control FSM.
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        aborted_d = aborted_q;
        count_d   = count_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (process_iseq_i) begin
                    state_d   = ST_RUN;
                    mask_d    = lane_mask_i;
                    aborted_d = 1'b0;
                    count_d   = '0;
                end
            end
            ST_RUN: begin
                // A handshake in the abort cycle still counts.
                count_d = count_sat;
                if (abort_iseq_i) begin
                    state_d = ST_FLUSH;
                end else if (run_done) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (flush_done) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Holding registers.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (pop[i]) begin
                valid_d[i]                              = 1'b1;
                data_d[i*INSTR_WIDTH +: INSTR_WIDTH]    = lane_fifo_data_i[i*INSTR_WIDTH +: INSTR_WIDTH];
            end else if (hs[i]) begin
                valid_d[i] = 1'b0;
            end
        end
        // Words held when an abort lands are dropped without being counted.
        if (state_d == ST_FLUSH) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            mask_q    <= '0;
            valid_q   <= '0;
            data_q    <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            mask_q    <= mask_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            count_q   <= count_d;
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign aborted_o      = aborted_q;
    assign instr_count_o  = count_q;
    assign lane_fifo_rd_o = pop;
    assign disp_valid_o   = valid_q;
    assign disp_data_o    = data_q;

endmodule

// File: tb/tb_iseq_dispatcher_mc.sv
module tb_iseq_dispatcher_mc;
    localparam int NL    = 2;
    localparam int W     = 32;
    localparam int CW    = 16;
    localparam int DEPTH = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            process_iseq = 1'b0;
    logic            abort_iseq   = 1'b0;
    logic [NL-1:0]   lane_mask    = '0;
    logic            busy, done, aborted;
    logic [CW-1:0]   instr_count;
    logic [NL-1:0]   fifo_rd, disp_valid;
    logic [NL-1:0]   fifo_empty = '1;
    logic [NL-1:0]   disp_ack   = '0;
    logic [NL*W-1:0] fifo_data  = '0;
    logic [NL*W-1:0] disp_data;

    iseq_dispatcher_mc #(.NUM_LANES(NL), .INSTR_WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .process_iseq_i(process_iseq), .lane_mask_i(lane_mask), .abort_iseq_i(abort_iseq),
        .busy_o(busy), .done_o(done), .aborted_o(aborted), .instr_count_o(instr_count),
        .lane_fifo_rd_o(fifo_rd), .lane_fifo_empty_i(fifo_empty), .lane_fifo_data_i(fifo_data),
        .disp_valid_o(disp_valid), .disp_data_o(disp_data), .disp_ack_i(disp_ack)
    );

    // Saturation instance: one lane, 3-bit counter.
    logic          s_process = 1'b0;
    logic          s_abort   = 1'b0;
    logic [0:0]    s_mask    = 1'b0;
    logic          s_busy, s_done, s_aborted;
    logic [2:0]    s_count;
    logic [0:0]    s_rd, s_empty, s_valid;
    logic [0:0]    s_ack = 1'b0;
    logic [W-1:0]  s_data, s_disp_data;
    int            s_total;
    int            s_popped;

    iseq_dispatcher_mc #(.NUM_LANES(1), .INSTR_WIDTH(W), .CNT_WIDTH(3)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .process_iseq_i(s_process), .lane_mask_i(s_mask), .abort_iseq_i(s_abort),
        .busy_o(s_busy), .done_o(s_done), .aborted_o(s_aborted), .instr_count_o(s_count),
        .lane_fifo_rd_o(s_rd), .lane_fifo_empty_i(s_empty), .lane_fifo_data_i(s_data),
        .disp_valid_o(s_valid), .disp_data_o(s_disp_data), .disp_ack_i(s_ack)
    );

    assign s_empty = (s_popped >= s_total);
    assign s_data  = 32'(s_popped);
    always @(posedge clk) if (rst_n && s_rd[0]) s_popped <= s_popped + 1;

    // FIFO model and monitors for the main instance.
    logic [W-1:0] mem [NL][DEPTH];
    int           wr_ptr [NL];
    int           rd_ptr [NL];
    logic [W-1:0] got [NL][DEPTH];
    int           got_n [NL];
    int           done_cnt, stab_err, fullpop_err, emptypop_err, rd1_cnt, v1_cnt;
    logic [NL-1:0] prev_hold = '0;
    logic [W-1:0]  prev_data [NL];

    int tests  = 0;
    int failed = 0;

    always @(posedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (fifo_rd[1]) rd1_cnt++;
            if (disp_valid[1]) v1_cnt++;
            for (int i = 0; i < NL; i++) begin
                if (fifo_rd[i]) begin
                    if (rd_ptr[i] == wr_ptr[i]) emptypop_err++;
                    else rd_ptr[i] <= rd_ptr[i] + 1;
                end
                if (prev_hold[i] && (!disp_valid[i] || disp_data[i*W +: W] !== prev_data[i])) stab_err++;
                if (disp_valid[i] && !disp_ack[i] && fifo_rd[i]) fullpop_err++;
                if (disp_valid[i] && disp_ack[i]) begin
                    got[i][got_n[i] % DEPTH] = disp_data[i*W +: W];
                    got_n[i]++;
                end
                prev_hold[i] = disp_valid[i] && !disp_ack[i];
                prev_data[i] = disp_data[i*W +: W];
            end
        end else begin
            prev_hold = '0;
        end
    end

    always @(negedge clk) begin
        #1;
        for (int i = 0; i < NL; i++) begin
            fifo_empty[i]       = (rd_ptr[i] == wr_ptr[i]);
            fifo_data[i*W +: W] = (rd_ptr[i] == wr_ptr[i]) ? '0 : mem[i][rd_ptr[i] % DEPTH];
        end
    end

    task automatic push(input int lane, input logic [W-1:0] w);
        mem[lane][wr_ptr[lane] % DEPTH] = w;
        wr_ptr[lane]++;
    endtask

    task automatic start_run(input logic [NL-1:0] m);
        lane_mask    = m;
        process_iseq = 1'b1;
        @(negedge clk);
        process_iseq = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_valid0(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (disp_valid[0]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests++;
        if ({busy, done, aborted} !== 3'b000) begin
            failed++; $display("FAIL reset_flags: got %b want 000", {busy, done, aborted});
        end
        tests++;
        if (instr_count !== '0 || disp_valid !== '0 || fifo_rd !== '0) begin
            failed++; $display("FAIL reset_count_valid_rd: got %0d %b %b want 0 00 00", instr_count, disp_valid, fifo_rd);
        end
        tests++;
        if (disp_data !== '0) begin
            failed++; $display("FAIL reset_data: got %h want 0", disp_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            failed++; $display("FAIL reset_release_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_basic();
        bit ok;
        int b0 = got_n[0];
        int b1 = got_n[1];
        int dc = done_cnt;
        for (int k = 0; k < 3; k++) push(0, 32'hA000_0000 + k);
        for (int k = 0; k < 2; k++) push(1, 32'hB000_0000 + k);
        disp_ack = 2'b11;
        start_run(2'b11);
        tests++;
        if (busy !== 1'b1) begin
            failed++; $display("FAIL basic_busy_rise: got %b want 1", busy);
        end
        wait_done(30, ok);
        tests++;
        if (!ok) begin
            failed++; $display("FAIL basic_done: got timeout want done");
        end
        tests++;
        if (instr_count !== 16'd5 || aborted !== 1'b0 || busy !== 1'b0) begin
            failed++; $display("FAIL basic_end: got cnt=%0d ab=%b busy=%b want 5 0 0", instr_count, aborted, busy);
        end
        tests++;
        if (got_n[0] - b0 != 3 || got_n[1] - b1 != 2) begin
            failed++; $display("FAIL basic_hs_per_lane: got %0d/%0d want 3/2", got_n[0] - b0, got_n[1] - b1);
        end
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (got[0][(b0 + k) % DEPTH] !== 32'hA000_0000 + k) begin
                failed++; $display("FAIL basic_lane0_order[%0d]: got %h want %h", k, got[0][(b0 + k) % DEPTH], 32'hA000_0000 + k);
            end
        end
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (got[1][(b1 + k) % DEPTH] !== 32'hB000_0000 + k) begin
                failed++; $display("FAIL basic_lane1_order[%0d]: got %h want %h", k, got[1][(b1 + k) % DEPTH], 32'hB000_0000 + k);
            end
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || done_cnt - dc != 1) begin
            failed++; $display("FAIL basic_done_pulse: got done=%b pulses=%0d want 0 1", done, done_cnt - dc);
        end
    endtask

    task automatic test_ack_toggle();
        bit ok = 1'b0;
        int b0 = got_n[0];
        int se = stab_err;
        int fe = fullpop_err;
        for (int k = 0; k < 4; k++) push(0, 32'hC000_0000 + k);
        disp_ack = 2'b01;
        start_run(2'b01);
        for (int k = 0; k < 40; k++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            disp_ack[0] = ~disp_ack[0];
            @(negedge clk);
        end
        tests++;
        if (!ok || instr_count !== 16'd4) begin
            failed++; $display("FAIL toggle_end: got done=%b cnt=%0d want 1 4", ok, instr_count);
        end
        tests++;
        if (stab_err - se != 0 || fullpop_err - fe != 0) begin
            failed++; $display("FAIL toggle_hold: got unstable=%0d pop_while_full=%0d want 0 0", stab_err - se, fullpop_err - fe);
        end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (got[0][(b0 + k) % DEPTH] !== 32'hC000_0000 + k) begin
                failed++; $display("FAIL toggle_order[%0d]: got %h want %h", k, got[0][(b0 + k) % DEPTH], 32'hC000_0000 + k);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_mask();
        bit ok;
        int r1 = rd1_cnt;
        int v1 = v1_cnt;
        push(0, 32'hE000_0000);
        push(0, 32'hE000_0001);
        for (int k = 0; k < 3; k++) push(1, 32'hF000_0000 + k);
        disp_ack = 2'b11;
        start_run(2'b01);
        wait_done(30, ok);
        tests++;
        if (!ok || instr_count !== 16'd2) begin
            failed++; $display("FAIL mask_end: got done=%b cnt=%0d want 1 2", ok, instr_count);
        end
        tests++;
        if (rd1_cnt - r1 != 0 || v1_cnt - v1 != 0) begin
            failed++; $display("FAIL mask_lane1_idle: got rd=%0d valid=%0d want 0 0", rd1_cnt - r1, v1_cnt - v1);
        end
        tests++;
        if (wr_ptr[1] - rd_ptr[1] != 3) begin
            failed++; $display("FAIL mask_lane1_fill: got %0d want 3", wr_ptr[1] - rd_ptr[1]);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        bit ok;
        bit vflag = 1'b0;
        int n;
        int b0 = got_n[0];
        for (int k = 0; k < 8; k++) push(0, 32'hD000_0000 + k);
        disp_ack = 2'b00;
        start_run(2'b01);
        wait_valid0(20, ok);
        tests++;
        if (!ok) begin
            failed++; $display("FAIL abort_first_valid: got timeout want valid");
        end
        disp_ack = 2'b01;
        @(negedge clk);
        disp_ack   = 2'b00;
        abort_iseq = 1'b1;
        tests++;
        if (disp_valid[0] !== 1'b1 || disp_data[W-1:0] !== 32'hD000_0001) begin
            failed++; $display("FAIL abort_held_word: got v=%b %h want 1 d0000001", disp_valid[0], disp_data[W-1:0]);
        end
        @(negedge clk);
        abort_iseq = 1'b0;
        n = 1;
        while (!done && n < 30) begin
            if (disp_valid !== '0) vflag = 1'b1;
            @(negedge clk);
            n++;
        end
        tests++;
        if (done !== 1'b1 || n != 8) begin
            failed++; $display("FAIL abort_flush_time: got done=%b cycles=%0d want 1 8", done, n);
        end
        tests++;
        if (vflag || aborted !== 1'b1 || instr_count !== 16'd1) begin
            failed++; $display("FAIL abort_end: got vflag=%b ab=%b cnt=%0d want 0 1 1", vflag, aborted, instr_count);
        end
        tests++;
        if (rd_ptr[0] != wr_ptr[0] || got_n[0] - b0 != 1 || got[0][b0 % DEPTH] !== 32'hD000_0000) begin
            failed++; $display("FAIL abort_drain: got left=%0d hs=%0d want 0 1", wr_ptr[0] - rd_ptr[0], got_n[0] - b0);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_mask_start_wins();
        lane_mask    = 2'b00;
        process_iseq = 1'b1;
        abort_iseq   = 1'b1;
        @(negedge clk);
        process_iseq = 1'b0;
        abort_iseq   = 1'b0;
        tests++;
        if (busy !== 1'b1 || done !== 1'b0 || aborted !== 1'b0) begin
            failed++; $display("FAIL zmask_start: got busy=%b done=%b ab=%b want 1 0 0", busy, done, aborted);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || instr_count !== '0 || aborted !== 1'b0) begin
            failed++; $display("FAIL zmask_done: got done=%b busy=%b cnt=%0d ab=%b want 1 0 0 0", done, busy, instr_count, aborted);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        bit ok;
        int rp;
        int b0;
        for (int k = 0; k < 4; k++) push(0, 32'h6000_0000 + k);
        disp_ack = 2'b00;
        start_run(2'b01);
        wait_valid0(20, ok);
        rp = rd_ptr[0];
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (!ok || {busy, done, aborted} !== 3'b000 || disp_valid !== '0 || fifo_rd !== '0
            || instr_count !== '0 || disp_data !== '0) begin
            failed++; $display("FAIL midreset_outputs: got busy=%b v=%b rd=%b cnt=%0d want all 0", busy, disp_valid, fifo_rd, instr_count);
        end
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (rd_ptr[0] != rp || wr_ptr[0] - rd_ptr[0] != 3) begin
            failed++; $display("FAIL midreset_no_pop: got left=%0d want 3", wr_ptr[0] - rd_ptr[0]);
        end
        rst_n = 1'b1;
        @(negedge clk);
        b0 = got_n[0];
        disp_ack = 2'b01;
        start_run(2'b01);
        wait_done(30, ok);
        tests++;
        if (!ok || instr_count !== 16'd3) begin
            failed++; $display("FAIL midreset_rerun: got done=%b cnt=%0d want 1 3", ok, instr_count);
        end
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (got[0][(b0 + k) % DEPTH] !== 32'h6000_0001 + k) begin
                failed++; $display("FAIL midreset_order[%0d]: got %h want %h", k, got[0][(b0 + k) % DEPTH], 32'h6000_0001 + k);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_saturate();
        bit ok = 1'b0;
        s_ack     = 1'b1;
        s_total   = 10;
        s_mask    = 1'b1;
        s_process = 1'b1;
        @(negedge clk);
        s_process = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (s_done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        tests++;
        if (!ok || s_count !== 3'd7) begin
            failed++; $display("FAIL sat_count: got done=%b cnt=%0d want 1 7", ok, s_count);
        end
        tests++;
        if (s_popped != 10 || s_busy !== 1'b0 || s_valid !== 1'b0 || s_aborted !== 1'b0 || s_disp_data !== 32'd9) begin
            failed++; $display("FAIL sat_end: got pops=%0d busy=%b v=%b last=%0d want 10 0 0 9", s_popped, s_busy, s_valid, s_disp_data);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ack_toggle();
        test_mask();
        test_abort();
        test_zero_mask_start_wins();
        test_reset_midrun();
        test_saturate();
        tests++;
        if (emptypop_err != 0) begin
            failed++; $display("FAIL empty_pop: got %0d want 0", emptypop_err);
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
